// File: rtl/wb_sram_pkg.sv
// Shared definitions for the Wishbone-to-SRAM controller and its response tag pipe.
// Contents: response tag bit layout, read-latency range limits, and
// elaboration-time helpers that validate the data-width and latency parameters.
package wb_sram_pkg;

  // Response tag layout: one valid bit and one error bit per in-flight transfer.
  localparam int unsigned TAG_W     = 2;
  localparam int unsigned TAG_VALID = 1;
  localparam int unsigned TAG_ERR   = 0;

  // Supported SRAM read latency range, in cycles.
  localparam int unsigned TICKS_MIN = 1;
  localparam int unsigned TICKS_MAX = 8;

  // Build a response tag from its fields.
  function automatic logic [TAG_W-1:0] tag_make(input logic valid, input logic err);
    logic [TAG_W-1:0] t;
    t            = '0;
    t[TAG_VALID] = valid;
    t[TAG_ERR]   = err;
    return t;
  endfunction

  // Data bus must be a whole number of bytes with one byte-enable per byte.
  function automatic bit width_ok(input int unsigned width, input int unsigned bytes);
    return (width != 0) && ((width % 8) == 0) && ((bytes * 8) == width);
  endfunction

  // Read latency must be inside the supported range.
  function automatic bit ticks_ok(input int unsigned ticks);
    return (ticks >= TICKS_MIN) && (ticks <= TICKS_MAX);
  endfunction

endpackage

// File: rtl/wb_tag_pipe.sv
// Fixed-latency response tag pipe.
// A DEPTH-deep shift register of {valid, err} tags. Stage 0 loads every cycle,
// the last stage presents the response. Reused by other bus bridges.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high clear of every stage
//   flush - synchronous clear of every stage (aborted bus cycle)
//   load  - tag entering stage 0
//   tail  - tag leaving the last stage
//   early - any valid tag in stages 0..DEPTH-2 (not yet at the tail)
//   busy  - any valid tag anywhere in the pipe
module wb_tag_pipe
  import wb_sram_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [TAG_W-1:0] load,
  output logic [TAG_W-1:0] tail,
  output logic             early,
  output logic             busy
);

  logic [DEPTH-1:0][TAG_W-1:0] stage;

  // Shift register with async clear and synchronous flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else if (flush) begin
      stage <= '0;
    end else begin
      stage[0] <= load;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tail = stage[DEPTH-1];

  // Occupancy: whole pipe, and everything short of the tail stage.
  always_comb begin
    busy  = 1'b0;
    early = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      busy = busy | stage[i][TAG_VALID];
      if (i < int'(DEPTH) - 1) begin
        early = early | stage[i][TAG_VALID];
      end
    end
  end

endmodule

// File: rtl/wb_sram_ctrl.sv
// Pipelined Wishbone slave in front of a single-port SRAM with fixed read latency.
// Every accepted request, read or write, answers exactly TICKS cycles later, so a
// plain tag shift register keeps responses ordered. Non-pipelined SRAMs are
// serialised with the stall output; out-of-range addresses answer with err_o.
// Ports:
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   cyc_i, stb_i, we_i    - Wishbone cycle, strobe, write enable
//   adr_i, sel_i, dat_i   - word address, byte selects, write data
//   ack_o, err_o, rty_o   - acknowledge, address error, retry (always 0)
//   wat_o                 - stall
//   dat_o                 - read data, non-zero only alongside a read ack
//   busy_o                - one or more transfers in flight
//   sram_ce_o, sram_we_o  - SRAM command enable and write
//   sram_adr_o            - SRAM address
//   sram_bes_o            - SRAM byte enables
//   sram_dat_o/sram_dat_i - SRAM write/read data
module wb_sram_ctrl
  import wb_sram_pkg::*;
#(
  parameter int unsigned ABITS = 10,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BYTES = WIDTH / 8,
  parameter int unsigned TICKS = 2,
  parameter int unsigned PIPED = 1,
  parameter int unsigned LIMIT = 2 ** ABITS,
  parameter int unsigned USEBE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  output logic             ack_o,
  output logic             wat_o,
  output logic             rty_o,
  output logic             err_o,
  input  logic [ABITS-1:0] adr_i,
  input  logic [BYTES-1:0] sel_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             busy_o,
  output logic             sram_ce_o,
  output logic             sram_we_o,
  output logic [ABITS-1:0] sram_adr_o,
  output logic [BYTES-1:0] sram_bes_o,
  input  logic [WIDTH-1:0] sram_dat_i,
  output logic [WIDTH-1:0] sram_dat_o
);

  // Elaboration-time parameter sanity.
  if (!width_ok(WIDTH, BYTES)) begin : g_bad_width
    $error("wb_sram_ctrl: WIDTH must be a non-zero multiple of 8 with BYTES = WIDTH/8");
  end
  if (!ticks_ok(TICKS)) begin : g_bad_ticks
    $error("wb_sram_ctrl: TICKS must be within 1..8");
  end

  logic             accept;
  logic             in_range;
  logic             flush;
  logic             early;
  logic             rd_last;
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_out;
  logic [TICKS-1:0] rd_q;

  assign accept = cyc_i && stb_i && !wat_o;
  assign flush  = !cyc_i;

  // Address range check; a limit covering the whole address space never errors.
  if (LIMIT >= 2 ** ABITS) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_limited
    localparam logic [ABITS-1:0] LIMIT_W = ABITS'(LIMIT);
    assign in_range = adr_i < LIMIT_W;
  end

  assign tag_in = tag_make(accept, accept && !in_range);

  // Fixed-latency response tracking.
  wb_tag_pipe #(
    .DEPTH(TICKS)
  ) u_tags (
    .clk  (clk_i),
    .rst  (rst_i),
    .flush(flush),
    .load (tag_in),
    .tail (tag_out),
    .early(early),
    .busy (busy_o)
  );

  // Read/write flag travelling alongside each tag, to gate read data onto dat_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q <= '0;
    end else if (flush) begin
      rd_q <= '0;
    end else begin
      rd_q[0] <= accept && !we_i;
      for (int i = 1; i < int'(TICKS); i++) begin
        rd_q[i] <= rd_q[i-1];
      end
    end
  end

  assign rd_last = rd_q[TICKS-1];

  // Responses are gated by cyc_i so a dropped cycle suppresses a response due now.
  assign ack_o = cyc_i && tag_out[TAG_VALID] && !tag_out[TAG_ERR];
  assign err_o = cyc_i && tag_out[TAG_VALID] && tag_out[TAG_ERR];
  assign rty_o = 1'b0;
  assign dat_o = (ack_o && rd_last) ? sram_dat_i : '0;

  // A single-command SRAM stalls until the outstanding tag reaches the tail,
  // so the next request is taken in the cycle the previous response issues.
  assign wat_o = (PIPED == 0) ? early : 1'b0;

  // SRAM command side.
  assign sram_ce_o  = accept && in_range;
  assign sram_we_o  = we_i;
  assign sram_adr_o = adr_i;
  assign sram_dat_o = dat_i;
  assign sram_bes_o = ((USEBE == 0) && we_i) ? {BYTES{1'b1}} : sel_i;

endmodule
